// File: rtl/cache_request_arbiter.sv
// Round-robin arbiter that shares one DynamicCache port among four requesters.
// Each access runs issue -> capture -> respond; hit/miss statistics saturate.
module cache_request_arbiter #(
    parameter int              NUM_REQ  = 4,
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 32,
    parameter logic [7:0]      PART_MAP = 8'b11_10_01_00
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        resp_hit,
    output logic [ADDR_W-1:0]           cache_addr,
    output logic                        cache_rw,
    output logic [DATA_W-1:0]           cache_wdata,
    output logic [1:0]                  cache_part,
    output logic [3:0]                  cache_intensity,
    input  logic [DATA_W-1:0]           cache_rdata,
    input  logic                        cache_hit,
    output logic [15:0]                 hit_count,
    output logic [15:0]                 miss_count,
    output logic                        busy
);

    // state   | meaning
    // IDLE    | no access in flight, arbitrate on any request
    // ISSUE   | cache inputs driven, ack the winner
    // CAPTURE | cache result valid, register response and statistics
    // RESP    | pulse resp_valid, may arbitrate straight into ISSUE
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          part_q, part_d;
    logic [3:0]          intensity_q, intensity_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_hit_q, resp_hit_d;
    logic [15:0]         hit_q, hit_d;
    logic [15:0]         miss_q, miss_d;

    logic [1:0]          win;
    logic                win_valid;
    logic                grant;
    logic [2:0]          req_cnt;

    // Scan downward so the requester closest to the pointer overwrites the others.
    always_comb begin
        win       = ptr_q;
        win_valid = |req_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
        end
    end

    assign grant = win_valid && (state_q == S_IDLE || state_q == S_RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            part_q      <= '0;
            intensity_q <= '0;
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            part_q      <= part_d;
            intensity_q <= intensity_d;
            resp_data_q <= resp_data_d;
            resp_hit_q  <= resp_hit_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (win_valid) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    state_d = win_valid ? S_ISSUE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        part_d      = part_q;
        resp_data_d = resp_data_q;
        resp_hit_d  = resp_hit_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        if (grant) begin
            gnt_d   = win;
            addr_d  = req_addr[int'(win)*ADDR_W +: ADDR_W];
            rw_d    = req_rw[win];
            wdata_d = req_wdata[int'(win)*DATA_W +: DATA_W];
            part_d  = PART_MAP[2*int'(win) +: 2];
        end
        if (state_q == S_CAPTURE) begin
            resp_hit_d  = cache_hit;
            resp_data_d = rw_q ? '0 : cache_rdata;
            ptr_d       = gnt_q + 2'd1;
            if (cache_hit) begin
                if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
            end else begin
                if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
            end
        end
    end

    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) req_cnt = req_cnt + {2'b00, req_valid[i]};
        case (req_cnt)
            3'd0:    intensity_d = 4'd0;
            3'd1:    intensity_d = 4'd4;
            3'd2:    intensity_d = 4'd8;
            3'd3:    intensity_d = 4'd12;
            default: intensity_d = 4'd15;
        endcase
    end

    // The cache has no enable: outside ISSUE it only sees a harmless re-read.
    always_comb begin
        req_ack    = '0;
        resp_valid = '0;
        if (state_q == S_ISSUE) req_ack[gnt_q]    = 1'b1;
        if (state_q == S_RESP)  resp_valid[gnt_q] = 1'b1;
        cache_rw        = (state_q == S_ISSUE) && rw_q;
        cache_addr      = addr_q;
        cache_wdata     = wdata_q;
        cache_part      = part_q;
        cache_intensity = intensity_q;
        resp_data       = resp_data_q;
        resp_hit        = resp_hit_q;
        hit_count       = hit_q;
        miss_count      = miss_q;
        busy            = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Self-checking bench for cache_request_arbiter: directed scenarios plus random
// request traffic compared against a simple round-robin / write-allocate cache model.
module tb_cache_request_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid, req_rw, req_ack, resp_valid;
    logic [63:0]   req_addr;
    logic [127:0]  req_wdata;
    logic [31:0]   resp_data, cache_wdata, cache_rdata;
    logic          resp_hit, cache_rw, cache_hit, busy;
    logic [15:0]   cache_addr, hit_count, miss_count;
    logic [1:0]    cache_part;
    logic [3:0]    cache_intensity;

    always #5 clk = ~clk;

    cache_request_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .cache_addr(cache_addr), .cache_rw(cache_rw), .cache_wdata(cache_wdata),
        .cache_part(cache_part), .cache_intensity(cache_intensity),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .hit_count(hit_count), .miss_count(miss_count), .busy(busy)
    );

    // Environment cache: writes allocate, read misses return DEADBEEF without filling.
    logic [31:0] env_mem [0:65535];
    bit          env_vld [0:65535];
    initial begin
        cache_hit   = 1'b0;
        cache_rdata = '0;
    end
    always @(posedge clk) begin
        cache_hit   <= env_vld[cache_addr];
        cache_rdata <= env_vld[cache_addr] ? env_mem[cache_addr] : 32'hDEADBEEF;
        if (cache_rw) begin
            env_vld[cache_addr] <= 1'b1;
            env_mem[cache_addr] <= cache_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:65535];
    bit          ref_vld [0:65535];
    int          ptr_m, hits_m, misses_m;
    logic [7:0]  pm = 8'b11_10_01_00;
    int          checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [3:0] rv);
        for (int k = 0; k < 4; k++) if (rv[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic int inten(input int n);
        return (n == 4) ? 15 : 4 * n;
    endfunction

    task automatic set_req(input int i, input logic rw, input logic [15:0] a, input logic [31:0] d);
        req_rw[i]              = rw;
        req_addr[16*i +: 16]   = a;
        req_wdata[32*i +: 32]  = d;
        req_valid[i]           = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},   32'(req_ack), 32'd0);
        check({tag, "_rv"},    32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, resp_data, 32'd0);
        check({tag, "_rhit"},  32'(resp_hit), 32'd0);
        check({tag, "_caddr"}, 32'(cache_addr), 32'd0);
        check({tag, "_crw"},   32'(cache_rw), 32'd0);
        check({tag, "_cwd"},   cache_wdata, 32'd0);
        check({tag, "_cpart"}, 32'(cache_part), 32'd0);
        check({tag, "_cint"},  32'(cache_intensity), 32'd0);
        check({tag, "_hits"},  32'(hit_count), 32'd0);
        check({tag, "_miss"},  32'(miss_count), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // Waits for an ack, checks the issued access, then follows it to its response.
    // Returns on the negedge inside the RESP cycle.
    task automatic serve(input int want_g, input bit keep, output int waitc);
        int          g;
        logic [15:0] a;
        logic        rw;
        logic [31:0] wd, exp_data;
        bit          exp_hit;
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (req_ack === 4'b0 && waitc < 12);
        check("ack_seen", 32'(req_ack != 4'b0), 32'd1);
        if (req_ack === 4'b0) return;
        g = rr_pick(ptr_m, req_valid);
        if (g < 0) begin
            check("ack_unrequested", 32'(req_ack), 32'd0);
            return;
        end
        check("ack", 32'(req_ack), 32'(4'b1 << g));
        if (want_g >= 0) check("ack_dir", 32'(req_ack), 32'(4'b1 << want_g));
        a  = req_addr[16*g +: 16];
        rw = req_rw[g];
        wd = req_wdata[32*g +: 32];
        check("issue_addr",  32'(cache_addr), 32'(a));
        check("issue_rw",    32'(cache_rw), 32'(rw));
        check("issue_wdata", cache_wdata, wd);
        check("issue_part",  32'(cache_part), 32'(pm[2*g +: 2]));
        check("intensity",   32'(cache_intensity), 32'(inten($countones(req_valid))));
        check("busy_issue",  32'(busy), 32'd1);
        exp_hit  = ref_vld[a];
        exp_data = rw ? 32'd0 : (exp_hit ? ref_mem[a] : 32'hDEADBEEF);
        if (rw) begin
            ref_vld[a] = 1'b1;
            ref_mem[a] = wd;
        end
        if (exp_hit) hits_m = (hits_m == 65535) ? hits_m : hits_m + 1;
        else         misses_m = (misses_m == 65535) ? misses_m : misses_m + 1;
        if (!keep) req_valid[g] = 1'b0;
        @(negedge clk);
        check("cap_rv",  32'(resp_valid), 32'd0);
        check("cap_rw",  32'(cache_rw), 32'd0);
        check("cap_ack", 32'(req_ack), 32'd0);
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'(4'b1 << g));
        check("resp_hit",   32'(resp_hit), 32'(exp_hit));
        check("resp_data",  resp_data, exp_data);
        check("hit_count",  32'(hit_count), 32'(hits_m));
        check("miss_count", 32'(miss_count), 32'(misses_m));
        ptr_m = (g + 1) % 4;
    endtask

    initial begin
        int w;
        int ri;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        reset     = 1'b1;
        ptr_m = 0; hits_m = 0; misses_m = 0;

        // All four requesters valid straight out of reset
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'h0200 + 16'(i), 32'd0);
        repeat (2) @(negedge clk);
        check_zero("rst");
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            serve(n % 4, 1'b1, w);
            check("rr_spacing", 32'(w), 32'd1);
        end
        check("all4_intensity", 32'(cache_intensity), 32'd15);
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0; hits_m = 0; misses_m = 0;

        // Write then read back on requester 0
        set_req(0, 1'b1, 16'h0001, 32'hA5A5A5A5);
        serve(0, 1'b0, w);
        check("wr_latency", 32'(w), 32'd1);
        check("wr_hit",  32'(resp_hit), 32'd0);
        check("wr_data", resp_data, 32'd0);
        check("wr_miss", 32'(miss_count), 32'd1);
        check("wr_part", 32'(cache_part), 32'd0);
        set_req(0, 1'b0, 16'h0001, 32'd0);
        serve(0, 1'b0, w);
        check("rd_hit",  32'(resp_hit), 32'd1);
        check("rd_data", resp_data, 32'hA5A5A5A5);
        check("rd_hits", 32'(hit_count), 32'd1);

        // Requester 2 reads a fresh line
        set_req(2, 1'b0, 16'h0021, 32'd0);
        serve(2, 1'b0, w);
        check("r2_part", 32'(cache_part), 32'd2);
        check("r2_hit",  32'(resp_hit), 32'd0);
        check("r2_data", resp_data, 32'hDEADBEEF);

        // Pointer to 2, then 1 and 3 compete: 3 wins, then 1
        set_req(1, 1'b0, 16'h0300, 32'd0);
        serve(1, 1'b0, w);
        set_req(1, 1'b1, 16'h0301, 32'h11112222);
        set_req(3, 1'b1, 16'h0303, 32'h33334444);
        serve(3, 1'b0, w);
        serve(1, 1'b0, w);
        check("b2b_spacing", 32'(w), 32'd1);

        // Random traffic over a small address window so hits and misses both occur
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), $urandom);
            end
            if (req_valid == 4'b0) begin
                ri = $urandom_range(0, 3);
                set_req(ri, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)), $urandom);
            end
            serve(-1, 1'b0, w);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        check("drain_idle", 32'(busy), 32'd0);

        // Reset while in CAPTURE abandons the access
        set_req(2, 1'b0, 16'h0021, 32'd0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (req_ack === 4'b0 && w < 12);
        check("rc_ack", 32'(req_ack), 32'b0100);
        req_valid = '0;
        @(negedge clk);
        check("rc_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1 check_zero("rst_cap");
        @(negedge clk);
        check("rc_no_resp", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        ptr_m = 0; hits_m = 0; misses_m = 0;
        set_req(0, 1'b0, 16'h0001, 32'd0);
        set_req(1, 1'b0, 16'h0400, 32'd0);
        serve(0, 1'b0, w);
        check("rc_after_data", resp_data, 32'hA5A5A5A5);
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
